// File: rtl/cis_scan_pkg.sv
// Shared state encoding and parameter defaults for the CIS line-scan controller.
package cis_scan_pkg;

  localparam int unsigned DEF_CLK_DIV      = 4;
  localparam int unsigned DEF_SI_CYC       = 8;
  localparam int unsigned DEF_PIX_PER_LINE = 5184;
  localparam int unsigned DEF_GAP_CYC      = 16;
  localparam int unsigned IDX_W            = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SI   = 3'd1,
    ST_PIX  = 3'd2,
    ST_GAP  = 3'd3,
    ST_DONE = 3'd4
  } scan_state_t;

endpackage

// File: rtl/cis_pix_timer.sv
// Pixel timer: divides clk_cis into cis_clk periods, strobes the last high
// cycle of each pixel and counts pixels within the line.
module cis_pix_timer
  import cis_scan_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic             clk_cis,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clear,
  output logic             clk_out,
  output logic             strobe,
  output logic [IDX_W-1:0] idx
);

  localparam int unsigned    PH_W    = $clog2(CLK_DIV);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0] PH_HALF = PH_W'(CLK_DIV / 2);

  logic [PH_W-1:0] ph;
  logic [PH_W-1:0] ph_nxt;
  logic            wrap;

  always_comb begin
    wrap   = (ph == PH_LAST);
    ph_nxt = wrap ? '0 : ph + PH_W'(1);
  end

  // clk_out/strobe are registered from the next phase so they line up with ph.
  always_ff @(posedge clk_cis or negedge rst_n) begin
    if (!rst_n) begin
      ph      <= '0;
      idx     <= '0;
      clk_out <= 1'b0;
      strobe  <= 1'b0;
    end else if (clear) begin
      ph      <= '0;
      idx     <= '0;
      clk_out <= 1'b0;
      strobe  <= 1'b0;
    end else if (enable) begin
      ph      <= ph_nxt;
      clk_out <= (ph_nxt >= PH_HALF);
      strobe  <= (ph_nxt == PH_LAST);
      if (wrap) begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/cis_scan_ctrl.sv
// Contact image sensor scan controller: sequences SI pulse, pixel clocking
// and inter-line gap for a programmable number of lines, with start-to-abort.
module cis_scan_ctrl
  import cis_scan_pkg::*;
#(
  parameter int unsigned CLK_DIV      = DEF_CLK_DIV,
  parameter int unsigned SI_CYC       = DEF_SI_CYC,
  parameter int unsigned PIX_PER_LINE = DEF_PIX_PER_LINE,
  parameter int unsigned GAP_CYC      = DEF_GAP_CYC
) (
  input  logic        clk_cis,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] line_num,
  output logic        cis_si,
  output logic        cis_clk,
  output logic        pix_valid,
  output logic [15:0] pix_idx,
  output logic [15:0] line_idx,
  output logic        busy,
  output logic        scan_done
);

  localparam int unsigned     CNT_MAX  = (SI_CYC > GAP_CYC) ? SI_CYC : GAP_CYC;
  localparam int unsigned     CNT_W    = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SI_LAST  = CNT_W'(SI_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
  localparam logic [15:0]      PIX_LAST = 16'(PIX_PER_LINE - 1);

  scan_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      lines;
  logic             abort;
  logic             line_end;
  logic             tmr_en;
  logic             tmr_clr;

  // Any start seen while busy (including DONE) is an abort, never a restart.
  always_comb begin
    abort    = busy & start;
    line_end = (state == ST_PIX) & pix_valid & (pix_idx == PIX_LAST);
    tmr_en   = (state == ST_PIX);
    tmr_clr  = ~tmr_en | line_end | abort;
  end

  cis_pix_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_timer (
    .clk_cis (clk_cis),
    .rst_n   (rst_n),
    .enable  (tmr_en),
    .clear   (tmr_clr),
    .clk_out (cis_clk),
    .strobe  (pix_valid),
    .idx     (pix_idx)
  );

  always_ff @(posedge clk_cis or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      lines     <= '0;
      line_idx  <= '0;
      cis_si    <= 1'b0;
      busy      <= 1'b0;
      scan_done <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      if (abort) begin
        state    <= ST_IDLE;
        cnt      <= '0;
        line_idx <= '0;
        cis_si   <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start && (line_num != 16'd0)) begin
              lines    <= line_num;
              line_idx <= '0;
              cnt      <= '0;
              cis_si   <= 1'b1;
              busy     <= 1'b1;
              state    <= ST_SI;
            end
          end
          ST_SI: begin
            if (cnt == SI_LAST) begin
              cnt    <= '0;
              cis_si <= 1'b0;
              state  <= ST_PIX;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          ST_PIX: begin
            if (line_end) begin
              cnt   <= '0;
              state <= ST_GAP;
            end
          end
          ST_GAP: begin
            if (cnt == GAP_LAST) begin
              cnt <= '0;
              if (line_idx == lines - 16'd1) begin
                scan_done <= 1'b1;
                state     <= ST_DONE;
              end else begin
                line_idx <= line_idx + 16'd1;
                cis_si   <= 1'b1;
                state    <= ST_SI;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          ST_DONE: begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/cis_scan_ctrl.md
CIS_SCAN_CTRL -- requirements
Module: cis_scan_ctrl

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 4: cis_clk period in clk_cis cycles; even, >=2.
REQ-002 SHALL provide parameter SI_CYC, default 8: cis_si high width in clk_cis cycles; >=1.
REQ-003 SHALL provide parameter PIX_PER_LINE, default 5184: pixels per line; 1..65535.
REQ-004 SHALL provide parameter GAP_CYC, default 16: idle cycles after each line; >=1.
REQ-005 SHALL have port clk_cis, input, 1: system clock.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port start, input, 1: one-cycle start pulse from the key debouncer.
REQ-008 SHALL have port line_num, input, 16: lines per scan, sampled on accepted start.
REQ-009 SHALL have port cis_si, output, 1: sensor start-integration pulse.
REQ-010 SHALL have port cis_clk, output, 1: sensor pixel clock.
REQ-011 SHALL have port pix_valid, output, 1: one-cycle ADC sample strobe per pixel.
REQ-012 SHALL have port pix_idx, output, 16: current pixel index in the line.
REQ-013 SHALL have port line_idx, output, 16: current line index in the scan.
REQ-014 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-015 SHALL have port scan_done, output, 1: one-cycle pulse when a scan completes normally.

Function
REQ-016 SHALL implement states IDLE, SI, PIX, GAP, DONE; all outputs registered.
REQ-017 In IDLE, start=1 with line_num!=0 SHALL latch line_num, clear line_idx, and enter SI next cycle; start with line_num=0 SHALL be ignored.
REQ-018 SI SHALL drive cis_si=1 for exactly SI_CYC cycles, with cis_clk=0 and pix_idx=0, then enter PIX.
REQ-019 In PIX, each pixel SHALL take CLK_DIV cycles: cis_clk low for CLK_DIV/2, then high for CLK_DIV/2.
REQ-020 pix_valid SHALL pulse on the last high cycle of each pixel, with pix_idx equal to that pixel's index.
REQ-021 pix_idx SHALL increment after each pixel; after pixel PIX_PER_LINE-1, the block SHALL enter GAP, never wrapping pix_idx mid-line.
REQ-022 GAP SHALL hold cis_clk=0 and cis_si=0 for GAP_CYC cycles.
REQ-023 At the end of GAP, if line_idx=latched_line_num-1, the block SHALL enter DONE; otherwise it SHALL increment line_idx and enter SI.
REQ-024 DONE SHALL last one cycle, with scan_done=1 and busy=1, then enter IDLE.
REQ-025 start=1 while busy SHALL abort: IDLE next cycle, cis_si/cis_clk/pix_valid low, no scan_done pulse, and no new scan begun from that pulse.
REQ-026 Abort SHALL take priority over every state transition, including the DONE cycle; an abort in DONE still delivers its scan_done pulse.
REQ-027 Changes on line_num while busy SHALL have no effect.

Reset
REQ-028 rst_n low SHALL force state IDLE and all outputs, counters and latched line_num to 0, asynchronously.
REQ-029 Reset released mid-scan SHALL leave the block in IDLE, waiting for a new start.

Structure
REQ-030 State encoding and parameter defaults SHALL live in a shared package, cis_scan_pkg.
REQ-031 The cis_clk phase/pixel counter SHALL be one sub-module, cis_pix_timer (enable, clear, clk_out, strobe, idx); the FSM stays in the top.

Verification
REQ-032 Params CLK_DIV=4, SI_CYC=3, PIX=8, GAP=2; start at t0 with line_num=2 -> cis_si high t1-t3 and t38-t40; first pix_valid at t7 with pix_idx=0; scan_done only at t75; busy t1-t75.
REQ-033 Same params: count pix_valid over the scan -> 16 pulses; pix_idx 0..7 per line; line_idx 0 then 1.
REQ-034 start with line_num=0 -> busy stays 0 and no cis_si.
REQ-035 Second start at t20 of a scan -> busy=0 at t21, no scan_done, and cis_clk=0 from t21.
REQ-036 rst_n low at t30 mid-PIX -> all outputs 0 immediately; after release, idle until the next start.
REQ-037 start at t75 (the DONE cycle) -> scan_done=1 at t75, IDLE at t76, and no new scan started.
